// File: rtl/serial_paralelo_param.sv
// Parametrised serial-to-parallel receiver: MSB-first bit stream, bit-level COM
// alignment, lock after LOCK_COUNT aligned COMs, WIDTH-bit data words with a valid strobe.
module serial_paralelo_param #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM        = 8'hBC,
    parameter logic [WIDTH-1:0] IDL        = 8'h7C,
    parameter int               LOCK_COUNT = 4
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    input  logic             resync,
    output logic             active,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic             sym_strobe
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (LOCK_COUNT > 0) ? $clog2(LOCK_COUNT + 1) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CW-1:0] LOCK_CW  = CW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Only the newest WIDTH-1 history bits are kept; they form the next compare window.
    logic [WIDTH-2:0] sr_r;
    logic [WIDTH-1:0] sr_next_s;
    logic [BW-1:0]    bit_cnt_r, bit_cnt_n_s;
    logic [CW-1:0]    com_cnt_r, com_cnt_n_s, com_inc_s;
    state_t           state_r, state_n_s;
    logic [WIDTH-1:0] data_n_s;
    logic             valid_n_s, strobe_n_s, boundary_s;

    function automatic logic is_ctrl(input logic [WIDTH-1:0] sym);
        return (sym == COM) || (sym == IDL);
    endfunction

    assign sr_next_s  = {sr_r, data_in};
    assign boundary_s = (bit_cnt_r == LAST_BIT);
    assign com_inc_s  = (com_cnt_r == LOCK_CW) ? com_cnt_r : com_cnt_r + CW'(1);

    // Next-state, counter and output-word decode; resync overrides everything.
    always_comb begin
        state_n_s   = state_r;
        bit_cnt_n_s = bit_cnt_r;
        com_cnt_n_s = com_cnt_r;
        data_n_s    = data_out;
        valid_n_s   = 1'b0;
        strobe_n_s  = 1'b0;
        if (resync) begin
            state_n_s   = ST_SEARCH;
            com_cnt_n_s = {CW{1'b0}};
            bit_cnt_n_s = {BW{1'b0}};
        end else begin
            case (state_r)
                ST_SEARCH: begin
                    bit_cnt_n_s = {BW{1'b0}};
                    if (sr_next_s == COM) begin
                        com_cnt_n_s = CW'(1);
                        state_n_s   = (LOCK_COUNT == 1) ? ST_ACTIVE : ST_ALIGN;
                    end else begin
                        com_cnt_n_s = {CW{1'b0}};
                    end
                end
                ST_ALIGN: begin
                    bit_cnt_n_s = boundary_s ? {BW{1'b0}} : bit_cnt_r + BW'(1);
                    if (boundary_s) begin
                        strobe_n_s = 1'b1;
                        if (sr_next_s == COM) begin
                            com_cnt_n_s = com_inc_s;
                            state_n_s   = (com_inc_s >= LOCK_CW) ? ST_ACTIVE : ST_ALIGN;
                        end else begin
                            com_cnt_n_s = {CW{1'b0}};
                            state_n_s   = ST_SEARCH;
                        end
                    end else begin
                        state_n_s = ST_ALIGN;
                    end
                end
                ST_ACTIVE: begin
                    bit_cnt_n_s = boundary_s ? {BW{1'b0}} : bit_cnt_r + BW'(1);
                    if (boundary_s) begin
                        strobe_n_s = 1'b1;
                        if (!is_ctrl(sr_next_s)) begin
                            data_n_s  = sr_next_s;
                            valid_n_s = 1'b1;
                        end else begin
                            valid_n_s = 1'b0;
                        end
                    end else begin
                        strobe_n_s = 1'b0;
                    end
                end
                default: begin
                    state_n_s   = ST_SEARCH;
                    bit_cnt_n_s = {BW{1'b0}};
                    com_cnt_n_s = {CW{1'b0}};
                end
            endcase
        end
    end

    // State, history and registered outputs.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_SEARCH;
            sr_r       <= {(WIDTH-1){1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
            com_cnt_r  <= {CW{1'b0}};
            active     <= 1'b0;
            valid_out  <= 1'b0;
            data_out   <= {WIDTH{1'b0}};
            sym_strobe <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            sr_r       <= sr_next_s[WIDTH-2:0];
            bit_cnt_r  <= bit_cnt_n_s;
            com_cnt_r  <= com_cnt_n_s;
            active     <= (state_n_s == ST_ACTIVE);
            valid_out  <= valid_n_s;
            data_out   <= data_n_s;
            sym_strobe <= strobe_n_s;
        end
    end

endmodule

// File: tb/tb_serial_paralelo_param.sv
// Bench for serial_paralelo_param: default 8-bit instance and a 10-bit/LOCK_COUNT=2
// instance, both checked every cycle against a symbol-level reference model.
module tb_serial_paralelo_param;

    localparam int M_SEARCH = 0;
    localparam int M_ALIGN  = 1;
    localparam int M_ACT    = 2;

    typedef struct {
        int          w;
        logic [15:0] com;
        logic [15:0] idl;
        int          lockn;
        int          mode;
        int          since;
        int          cnt;
        logic [15:0] word;
        logic [15:0] data;
        bit          active;
        bit          valid;
        bit          strobe;
    } model_t;

    logic       clk;
    logic       rst_n;
    logic       din8, rs8, din10, rs10;
    logic       active8, valid8, strobe8;
    logic [7:0] data8;
    logic       active10, valid10, strobe10;
    logic [9:0] data10;

    int  vectors;
    int  miscompares;
    int  cyc;
    int  valid_cnt8;
    int  last_strobe10;
    bit  period_chk;
    model_t m8, m10;

    serial_paralelo_param dut8 (
        .clk_32f(clk), .reset(rst_n), .data_in(din8), .resync(rs8),
        .active(active8), .valid_out(valid8), .data_out(data8), .sym_strobe(strobe8)
    );

    serial_paralelo_param #(
        .WIDTH(10), .COM(10'h17C), .IDL(10'h0F8), .LOCK_COUNT(2)
    ) dut10 (
        .clk_32f(clk), .reset(rst_n), .data_in(din10), .resync(rs10),
        .active(active10), .valid_out(valid10), .data_out(data10), .sym_strobe(strobe10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic model_t model_init(input int w, input logic [15:0] com,
                                          input logic [15:0] idl, input int lockn);
        model_t n;
        n.w = w; n.com = com; n.idl = idl; n.lockn = lockn;
        n.mode = M_SEARCH; n.since = 0; n.cnt = 0;
        n.word = 16'h0; n.data = 16'h0;
        n.active = 1'b0; n.valid = 1'b0; n.strobe = 1'b0;
        return n;
    endfunction

    // One received bit: the window is the last w bits seen; boundaries fall every
    // w bits after the COM that started alignment.
    function automatic model_t model_step(input model_t m, input bit b, input bit rs);
        model_t      n;
        logic [15:0] mask;
        n    = m;
        mask = 16'hFFFF >> (16 - m.w);
        n.word   = ((m.word << 1) | {15'd0, b}) & mask;
        n.valid  = 1'b0;
        n.strobe = 1'b0;
        if (rs) begin
            n.mode = M_SEARCH;
            n.cnt  = 0;
        end else if (n.mode == M_SEARCH) begin
            if (n.word == n.com) begin
                n.since = 0;
                n.cnt   = 1;
                n.mode  = (n.lockn == 1) ? M_ACT : M_ALIGN;
            end
        end else begin
            n.since++;
            if (n.since % n.w == 0) begin
                n.strobe = 1'b1;
                if (n.mode == M_ALIGN) begin
                    if (n.word == n.com) begin
                        n.cnt++;
                        if (n.cnt >= n.lockn) n.mode = M_ACT;
                    end else begin
                        n.cnt  = 0;
                        n.mode = M_SEARCH;
                    end
                end else if (n.word != n.com && n.word != n.idl) begin
                    n.data  = n.word;
                    n.valid = 1'b1;
                end
            end
        end
        n.active = (n.mode == M_ACT);
        return n;
    endfunction

    task automatic reinit_models();
        m8  = model_init(8, 16'h00BC, 16'h007C, 4);
        m10 = model_init(10, 16'h017C, 16'h00F8, 2);
    endtask

    task automatic compare_all();
        check_val("active8", active8, m8.active);
        check_val("valid8", valid8, m8.valid);
        check_val("data8", data8, m8.data);
        check_val("strobe8", strobe8, m8.strobe);
        check_val("active10", active10, m10.active);
        check_val("valid10", valid10, m10.valid);
        check_val("data10", data10, m10.data);
        check_val("strobe10", strobe10, m10.strobe);
    endtask

    // Drive one bit per instance, advance one clock, compare at the falling edge.
    task automatic tick(input bit b8, input bit r8, input bit b10, input bit r10);
        din8 = b8; rs8 = r8; din10 = b10; rs10 = r10;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            reinit_models();
        end else begin
            m8  = model_step(m8, b8, r8);
            m10 = model_step(m10, b10, r10);
        end
        @(negedge clk);
        compare_all();
        if (valid8) valid_cnt8++;
        if (period_chk && strobe10) begin
            if (last_strobe10 >= 0) check_val("strobe_period10", cyc - last_strobe10, 10);
            last_strobe10 = cyc;
        end
        rs8 = 1'b0; rs10 = 1'b0;
    endtask

    task automatic send8(input logic [7:0] s);
        for (int i = 7; i >= 0; i--) tick(s[i], 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send8_resync_last(input logic [7:0] s);
        for (int i = 7; i >= 0; i--) tick(s[i], (i == 0), 1'b0, 1'b0);
    endtask

    task automatic send10(input logic [9:0] s);
        for (int i = 9; i >= 0; i--) tick(1'b0, 1'b0, s[i], 1'b0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; valid_cnt8 = 0;
        last_strobe10 = -1; period_chk = 1'b0;
        din8 = 1'b0; rs8 = 1'b0; din10 = 1'b0; rs10 = 1'b0;
        rst_n = 1'b0;
        reinit_models();
        @(negedge clk);
        check_val("reset_active8", active8, 1'b0);
        check_val("reset_data8", data8, 8'h00);
        check_val("reset_data10", data10, 10'h000);

        // Default lock and data delivery
        apply_reset();
        for (int i = 0; i < 3; i++) send8(8'hBC);
        check_val("no_lock_after_3com", active8, 1'b0);
        send8(8'hBC);
        check_val("lock_after_32", active8, 1'b1);
        valid_cnt8 = 0;
        send8(8'hA5);
        check_val("data_a5", data8, 8'hA5);
        check_val("valid_a5", valid8, 1'b1);
        send8(8'h7C);
        check_val("idle_no_valid", valid_cnt8, 1);
        send8(8'h3C);
        check_val("data_3c", data8, 8'h3C);
        check_val("two_valids", valid_cnt8, 2);

        // Bit misalignment
        apply_reset();
        for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send8(8'hBC);
        valid_cnt8 = 0;
        send8(8'h11);
        check_val("misalign_lock", active8, 1'b1);
        check_val("misalign_data", data8, 8'h11);
        check_val("misalign_one_valid", valid_cnt8, 1);

        // Broken comma run, then resync
        apply_reset();
        send8(8'hBC); send8(8'hBC); send8(8'h55);
        check_val("broken_no_lock", active8, 1'b0);
        for (int i = 0; i < 3; i++) send8(8'hBC);
        check_val("broken_no_lock_3", active8, 1'b0);
        send8(8'hBC);
        check_val("broken_relock", active8, 1'b1);
        send8(8'h22);
        check_val("broken_data", data8, 8'h22);
        send8_resync_last(8'h99);
        check_val("resync_drop", active8, 1'b0);
        check_val("resync_no_valid", valid8, 1'b0);
        check_val("resync_hold_data", data8, 8'h22);
        for (int i = 0; i < 4; i++) send8(8'hBC);
        check_val("resync_relock", active8, 1'b1);
        send8(8'h5A);
        check_val("resync_data", data8, 8'h5A);

        // 10-bit instance, LOCK_COUNT=2
        apply_reset();
        period_chk = 1'b1; last_strobe10 = -1;
        send10(10'h17C);
        check_val("w10_no_lock_1", active10, 1'b0);
        send10(10'h17C);
        check_val("w10_lock_20", active10, 1'b1);
        send10(10'h2AA);
        check_val("w10_data", data10, 10'h2AA);
        check_val("w10_valid", valid10, 1'b1);
        send10(10'h0F8);
        send10(10'h155);
        check_val("w10_data2", data10, 10'h155);
        period_chk = 1'b0;

        // Asynchronous reset in the middle of a symbol while locked
        apply_reset();
        for (int i = 0; i < 4; i++) send8(8'hBC);
        for (int i = 7; i >= 5; i--) tick(1'b1, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_val("areset_active", active8, 1'b0);
        check_val("areset_valid", valid8, 1'b0);
        check_val("areset_data", data8, 8'h00);
        check_val("areset_strobe", strobe8, 1'b0);
        reinit_models();
        @(negedge clk);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        valid_cnt8 = 0;
        for (int i = 0; i < 3; i++) send8(8'hBC);
        send8(8'h11);
        check_val("areset_needs_4com", valid_cnt8, 0);
        for (int i = 0; i < 4; i++) send8(8'hBC);
        send8(8'h11);
        check_val("areset_relock_valid", valid_cnt8, 1);

        // Randomized traffic on the 8-bit instance
        apply_reset();
        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                int k;
                k = $urandom_range(1, 4);
                for (int j = 0; j < k; j++) send8(8'hBC);
            end else if (r == 4) begin
                int k;
                k = $urandom_range(1, 7);
                for (int j = 0; j < k; j++) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
            end else if (r == 5) begin
                send8(8'h7C);
            end else if (r == 6) begin
                tick(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
            end else begin
                send8(8'($urandom));
            end
        end

        // Randomized traffic on the 10-bit instance
        for (int it = 0; it < 150; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                send10(10'h17C);
            end else if (r == 4) begin
                int k;
                k = $urandom_range(1, 9);
                for (int j = 0; j < k; j++) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end else if (r == 5) begin
                send10(10'h0F8);
            end else if (r == 6) begin
                tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
            end else begin
                send10(10'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
